// File: rtl/fib_bcd_gen.sv
// fib_bcd_gen: BCD Fibonacci engine.
// Converts a BCD index n to binary, then iterates BCD additions to produce F(n)
// as an OUT_DIGITS-digit BCD vector. It aborts early when F(n) cannot be
// represented, flags invalid index digits, and can optionally emit every term
// F(0)..F(n) as it is generated.
// Ports:
//   iCLK, iRESET_N   clock (rising edge), asynchronous active-low reset
//   iSTART           start request, accepted only while oREADY=1
//   iSEQ             1 = emit each term F(0)..F(n) with oTERM_VALID
//   iBCD_N           index n, BCD, digit 0 in [3:0]
//   oREADY           high while idle
//   oDONE            one-cycle pulse; oBCD/oOFLOW/oERR are valid
//   oOFLOW           F(n) does not fit in OUT_DIGITS digits (oBCD = all 9s)
//   oERR             iBCD_N held a digit > 9 (oBCD = 0)
//   oTERM_VALID      sequence mode: oBCD holds a new term
//   oBCD             result or current term, BCD, digit 0 in [3:0]
module fib_bcd_gen #(
  parameter int unsigned IN_DIGITS  = 2,
  parameter int unsigned OUT_DIGITS = 4,
  parameter int unsigned CNT_W      = 7
) (
  input  logic                    iCLK,
  input  logic                    iRESET_N,
  input  logic                    iSTART,
  input  logic                    iSEQ,
  input  logic [4*IN_DIGITS-1:0]  iBCD_N,
  output logic                    oREADY,
  output logic                    oDONE,
  output logic                    oOFLOW,
  output logic                    oERR,
  output logic                    oTERM_VALID,
  output logic [4*OUT_DIGITS-1:0] oBCD
);

  localparam int unsigned IN_W  = 4 * IN_DIGITS;
  localparam int unsigned OUT_W = 4 * OUT_DIGITS;
  localparam int unsigned DIG_W = (IN_DIGITS > 1) ? $clog2(IN_DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_CALC,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IN_W-1:0]    n_q, n_d;
  logic               seq_q, seq_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIG_W-1:0]   dig_q, dig_d;
  logic [OUT_W-1:0]   t0_q, t0_d;
  logic [OUT_W-1:0]   t1_q, t1_d;
  logic [OUT_W-1:0]   bcd_q, bcd_d;
  logic               oflow_q, oflow_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               tv_q, tv_d;
  logic               ready_q, ready_d;

  logic               in_bad_c;
  logic [3:0]         cur_digit_c;
  logic [OUT_W-1:0]   sum_c;
  logic               carry_c;

  // Any index digit above 9 makes the request invalid.
  always_comb begin
    in_bad_c = 1'b0;
    for (int i = 0; i < int'(IN_DIGITS); i++) begin
      if (iBCD_N[4*i +: 4] > 4'd9) begin
        in_bad_c = 1'b1;
      end
    end
  end

  // Latched index digit currently being folded into the binary counter.
  always_comb begin
    cur_digit_c = 4'd0;
    for (int i = 0; i < int'(IN_DIGITS); i++) begin
      if (DIG_W'(i) == dig_q) begin
        cur_digit_c = n_q[4*i +: 4];
      end
    end
  end

  // Ripple BCD adder t0 + t1 with +6 decimal correction per digit.
  always_comb begin : bcd_add
    logic       c;
    logic [4:0] s;
    c     = 1'b0;
    s     = 5'd0;
    sum_c = '0;
    for (int i = 0; i < int'(OUT_DIGITS); i++) begin
      s = 5'(t0_q[4*i +: 4]) + 5'(t1_q[4*i +: 4]) + 5'(c);
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      sum_c[4*i +: 4] = s[3:0];
    end
    carry_c = c;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    bcd_d   = bcd_q;
    oflow_d = oflow_q;
    err_d   = err_q;
    done_d  = 1'b0;
    tv_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (iSTART) begin
          n_d     = iBCD_N;
          seq_d   = iSEQ;
          oflow_d = 1'b0;
          err_d   = 1'b0;
          if (in_bad_c) begin
            err_d   = 1'b1;
            bcd_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d   = '0;
            dig_d   = DIG_W'(IN_DIGITS - 1);
            state_d = S_CONV;
          end
        end
      end

      // Most significant digit first: cnt = cnt*10 + digit.
      S_CONV: begin
        cnt_d = CNT_W'(cnt_q * CNT_W'(10)) + CNT_W'(cur_digit_c);
        if (dig_q == '0) begin
          t0_d    = '0;
          t1_d    = OUT_W'(1);
          state_d = S_CALC;
        end else begin
          dig_d = dig_q - DIG_W'(1);
        end
      end

      // t0 = F(k), t1 = F(k+1), cnt = n-k. A carry while cnt >= 2 means
      // F(n) itself overflows; at cnt == 1 only the unused F(n+1) does.
      S_CALC: begin
        if (cnt_q == '0) begin
          bcd_d   = t0_q;
          tv_d    = seq_q;
          state_d = S_DONE;
        end else if (carry_c && (cnt_q >= CNT_W'(2))) begin
          oflow_d = 1'b1;
          bcd_d   = {OUT_DIGITS{4'h9}};
          state_d = S_DONE;
        end else begin
          t0_d  = t1_q;
          t1_d  = sum_c;
          cnt_d = cnt_q - CNT_W'(1);
          if (seq_q) begin
            bcd_d = t0_q;
            tv_d  = 1'b1;
          end
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      seq_q   <= 1'b0;
      cnt_q   <= '0;
      dig_q   <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      bcd_q   <= '0;
      oflow_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      tv_q    <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      bcd_q   <= bcd_d;
      oflow_q <= oflow_d;
      err_q   <= err_d;
      done_q  <= done_d;
      tv_q    <= tv_d;
      ready_q <= ready_d;
    end
  end

  assign oREADY      = ready_q;
  assign oDONE       = done_q;
  assign oOFLOW      = oflow_q;
  assign oERR        = err_q;
  assign oTERM_VALID = tv_q;
  assign oBCD        = bcd_q;

endmodule

// File: tb/tb_fib_bcd_gen.sv
// tb_fib_bcd_gen: scoreboard bench for fib_bcd_gen (IN_DIGITS=2, OUT_DIGITS=4).
// Expected results and sequence terms are queued when a request is driven and
// consumed when the DUT pulses oDONE / oTERM_VALID.
module tb_fib_bcd_gen;

  localparam int unsigned IN_DIGITS = 2;

  typedef struct {
    logic [15:0] bcd;
    logic        oflow;
    logic        err;
    int unsigned lat;
    int unsigned start;
  } exp_t;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        iSTART = 1'b0;
  logic        iSEQ   = 1'b0;
  logic [7:0]  iBCD_N = 8'h00;
  logic        oREADY, oDONE, oOFLOW, oERR, oTERM_VALID;
  logic [15:0] oBCD;

  int unsigned cyc      = 0;
  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;
  int unsigned done_cnt = 0;

  exp_t        exp_q[$];
  logic [15:0] term_q[$];
  exp_t        mon_e;
  logic [15:0] mon_t;

  fib_bcd_gen #(
    .IN_DIGITS (2),
    .OUT_DIGITS(4),
    .CNT_W     (7)
  ) dut (
    .iCLK       (clk),
    .iRESET_N   (rst_n),
    .iSTART     (iSTART),
    .iSEQ       (iSEQ),
    .iBCD_N     (iBCD_N),
    .oREADY     (oREADY),
    .oDONE      (oDONE),
    .oOFLOW     (oOFLOW),
    .oERR       (oERR),
    .oTERM_VALID(oTERM_VALID),
    .oBCD       (oBCD)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int unsigned v);
    logic [15:0] r;
    int unsigned x;
    r = 16'h0;
    x = v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference model: queue final result, latency and (in sequence mode) every term.
  task automatic expect_op(input logic [7:0] nb, input bit seq, input int unsigned start);
    exp_t        e;
    int unsigned n, f0, f1, f2, kend;
    e.start = start;
    e.err   = 1'b0;
    e.oflow = 1'b0;
    if (nb[7:4] > 4'd9 || nb[3:0] > 4'd9) begin
      e.err = 1'b1;
      e.bcd = 16'h0000;
      e.lat = 1;
    end else begin
      n    = 32'(nb[7:4]) * 10 + 32'(nb[3:0]);
      f0   = 0;
      f1   = 1;
      kend = n;
      for (int unsigned k = 0; k < n; k++) begin
        if ((n - k) >= 2 && (f0 + f1) >= 10000) begin
          e.oflow = 1'b1;
          kend    = k;
          break;
        end
        if (seq) term_q.push_back(to_bcd(f0));
        f2 = f0 + f1;
        f0 = f1;
        f1 = f2;
      end
      if (!e.oflow && seq) term_q.push_back(to_bcd(f0));
      e.bcd = e.oflow ? 16'h9999 : to_bcd(f0);
      e.lat = IN_DIGITS + kend + 2;
    end
    exp_q.push_back(e);
  endtask

  task automatic start_op(input logic [7:0] nb, input bit seq);
    iBCD_N = nb;
    iSEQ   = seq;
    iSTART = 1'b1;
    @(posedge clk);
    #1;
    iSTART = 1'b0;
    expect_op(nb, seq, cyc);
    chk("busy_after_start", 32'(oREADY), 32'd0);
  endtask

  task automatic wait_idle();
    int unsigned i;
    i = 0;
    while (exp_q.size() != 0 && i < 300) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("drained", 32'(exp_q.size()), 32'd0);
    chk("terms_left", 32'(term_q.size()), 32'd0);
    chk("ready_idle", 32'(oREADY), 32'd1);
    exp_q.delete();
    term_q.delete();
  endtask

  // Output monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (oTERM_VALID) begin
        chk("term_pending", 32'(term_q.size() != 0), 32'd1);
        if (term_q.size() != 0) begin
          mon_t = term_q.pop_front();
          chk("term", 32'(oBCD), 32'(mon_t));
        end
      end
      if (oDONE) begin
        done_cnt++;
        chk("done_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("bcd", 32'(oBCD), 32'(mon_e.bcd));
          chk("oflow", 32'(oOFLOW), 32'(mon_e.oflow));
          chk("err", 32'(oERR), 32'(mon_e.err));
          chk("latency", cyc - mon_e.start, mon_e.lat);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] tbl_n[10] = '{8'h00, 8'h01, 8'h02, 8'h20, 8'h21, 8'h3A, 8'h07, 8'h21, 8'hA5, 8'h12};
  bit         tbl_s[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int unsigned base;
    int unsigned rn;
    int unsigned i;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(oREADY), 32'd1);
    chk("rst_bcd", 32'(oBCD), 32'd0);
    chk("rst_done", 32'(oDONE), 32'd0);
    chk("rst_oflow", 32'(oOFLOW), 32'd0);
    chk("rst_err", 32'(oERR), 32'd0);
    chk("rst_term", 32'(oTERM_VALID), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a calculation aborts it silently.
    start_op(8'h15, 1'b0);
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    term_q.delete();
    #1;
    chk("midrst_ready", 32'(oREADY), 32'd1);
    chk("midrst_bcd", 32'(oBCD), 32'd0);
    chk("midrst_done", 32'(oDONE), 32'd0);
    base = done_cnt;
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("no_done_after_rst", done_cnt, base);

    start_op(8'h15, 1'b0);
    wait_idle();

    for (int k = 0; k < 10; k++) begin
      start_op(tbl_n[k], tbl_s[k]);
      wait_idle();
    end

    // A start request while busy is ignored.
    start_op(8'h10, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    iBCD_N = 8'h05;
    iSTART = 1'b1;
    @(posedge clk);
    #1;
    iSTART = 1'b0;
    wait_idle();

    // iSTART held high restarts on the idle cycle that carries oDONE.
    iBCD_N = 8'h03;
    iSEQ   = 1'b0;
    iSTART = 1'b1;
    @(posedge clk);
    #1;
    expect_op(8'h03, 1'b0, cyc);
    i = 0;
    while (!oDONE && i < 100) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("held_first_done", 32'(oDONE), 32'd1);
    expect_op(8'h03, 1'b0, cyc + 1);
    @(posedge clk);
    #1;
    iSTART = 1'b0;
    chk("held_restart_busy", 32'(oREADY), 32'd0);
    wait_idle();

    repeat (6) begin
      rn = $urandom_range(0, 24);
      start_op({4'(rn / 10), 4'(rn % 10)}, 1'($urandom_range(0, 1)));
      wait_idle();
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
